// File: rtl/ref_clk_divider.sv
// Reference clock divider with a one-hot select (/32../512) and glitch-free ratio switching.
// A new select is only applied on a period boundary, so div_clk_out never produces a runt phase.
`timescale 1ns/1ps
module ref_clk_divider (
   input  logic       clk,
   input  logic       rstn,
   input  logic [4:0] tgate_control,
   output logic       div_clk_out,
   output logic       div_tick,
   output logic [4:0] div_sel_active,
   output logic       sel_pending,
   output logic       sel_err
);

   localparam logic [4:0] SEL_RST = 5'b00010;

   logic [8:0] cnt;
   logic [4:0] act;
   logic [4:0] pend;

   logic       wrap;
   logic       sel_legal;
   logic [8:0] cnt_nxt;
   logic [4:0] act_nxt;

   function automatic logic [8:0] last_cnt(input logic [4:0] sel);
      case (sel)
         5'b00001: last_cnt = 9'd511;
         5'b00010: last_cnt = 9'd255;
         5'b00100: last_cnt = 9'd127;
         5'b01000: last_cnt = 9'd63;
         5'b10000: last_cnt = 9'd31;
         default:  last_cnt = 9'd255;
      endcase
   endfunction

   function automatic logic [8:0] half_cnt(input logic [4:0] sel);
      case (sel)
         5'b00001: half_cnt = 9'd256;
         5'b00010: half_cnt = 9'd128;
         5'b00100: half_cnt = 9'd64;
         5'b01000: half_cnt = 9'd32;
         5'b10000: half_cnt = 9'd16;
         default:  half_cnt = 9'd128;
      endcase
   endfunction

   always_comb begin
      sel_legal = (tgate_control != 5'd0) &&
                  ((tgate_control & (tgate_control - 5'd1)) == 5'd0);
      wrap      = (cnt == last_cnt(act));
      cnt_nxt   = wrap ? 9'd0 : cnt + 9'd1;
      // the ratio only changes on a wrap, so the old period always completes
      act_nxt   = wrap ? pend : act;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt         <= 9'd0;
         act         <= SEL_RST;
         pend        <= SEL_RST;
         div_clk_out <= 1'b0;
         div_tick    <= 1'b0;
         sel_err     <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         act         <= act_nxt;
         if (sel_legal)
            pend <= tgate_control;
         sel_err     <= ~sel_legal;
         div_tick    <= wrap;
         // compare against the post-edge count and ratio so the output tracks the new period
         div_clk_out <= (cnt_nxt >= half_cnt(act_nxt));
      end
   end

   assign div_sel_active = act;
   assign sel_pending    = (pend != act);

endmodule
